// File: rtl/gpu_fb_writer_pkg.sv
// Shared definitions for the pGB frame-buffer writer.
// Frame geometry (256x256 px at 2 bpp), packer widths and writer FSM states.
package gpu_fb_writer_pkg;

    localparam int unsigned FB_WORDS        = 8192;
    localparam int unsigned FB_PIX_PER_WORD = 8;
    localparam int unsigned FB_ROW_WORDS    = 32;
    localparam int unsigned PIX_BITS        = 2;
    localparam int unsigned ADDR_W          = 16;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic [1:0] {
        FBW_IDLE   = 2'd0,
        FBW_ACTIVE = 2'd1,
        FBW_DRAIN  = 2'd2
    } fbwState_t;

endpackage

// File: rtl/gpu_fb_pixel_packer.sv
// Packs a serial 2-bit pixel stream into 16-bit words, first pixel in the MSBs.
// Ports:
//   iClock, iReset      clock, synchronous active-high reset
//   iClear              drop any partial word and restart at pixel 0
//   iShift              a pixel is accepted this cycle
//   iPixel              pixel shade
//   oWord_c             word as it would be if iPixel completes it
//   oLastPixel_c        next accepted pixel is pixel 7 of the word
//   oWordDone_c         pixel 7 is accepted this cycle
module gpu_fb_pixel_packer
    import gpu_fb_writer_pkg::*;
(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iClear,
    input  logic                iShift,
    input  logic [PIX_BITS-1:0] iPixel,
    output logic [DATA_W-1:0]   oWord_c,
    output logic                oLastPixel_c,
    output logic                oWordDone_c
);

    // Only the 7 previous pixels need storage; the 8th comes straight from iPixel.
    logic [DATA_W-PIX_BITS-1:0] rShift;
    logic [CNT_W-1:0]           rCount;

    always_ff @(posedge iClock) begin
        if (iReset || iClear) begin
            rShift <= '0;
            rCount <= '0;
        end else if (iShift) begin
            rShift <= oWord_c[DATA_W-PIX_BITS-1:0];
            rCount <= rCount + CNT_W'(1);
        end
    end

    assign oWord_c      = {rShift, iPixel};
    assign oLastPixel_c = (rCount == CNT_W'(FB_PIX_PER_WORD - 1));
    assign oWordDone_c  = iShift && oLastPixel_c;

endmodule

// File: rtl/gpu_fb_writer.sv
// Transmit end of the pGB frame-buffer port: packs GPU pixels into words and
// writes them to the LCD-board frame buffer with a We/Ready handshake.
// Ports:
//   iClock, iReset                      clock, synchronous active-high reset
//   iFrameStart                         begin a new frame at address 0
//   iPixelValid, iPixel, oPixelReady    pixel stream (oPixelReady is combinational)
//   iFrameBufferReady                   sink accepts the word when We&Ready
//   oFrameBufferWe/Addr/Data            registered word write toward the sink
//   oFrameDone                          pulse after the last word is accepted
//   oFrameAbort                         pulse when a frame is restarted early
//   oFrameCount                         completed frames, wrapping
module gpu_fb_writer
    import gpu_fb_writer_pkg::*;
(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iFrameStart,
    input  logic                iPixelValid,
    input  logic [PIX_BITS-1:0] iPixel,
    output logic                oPixelReady,
    input  logic                iFrameBufferReady,
    output logic                oFrameBufferWe,
    output logic [ADDR_W-1:0]   oFrameBufferAddr,
    output logic [DATA_W-1:0]   oFrameBufferData,
    output logic                oFrameDone,
    output logic                oFrameAbort,
    output logic [15:0]         oFrameCount
);

    fbwState_t          rState, nState;
    logic [ADDR_W-1:0]  rWordAddr, nWordAddr;
    logic               nWe, nDone, nAbort;
    logic [ADDR_W-1:0]  nAddr;
    logic [DATA_W-1:0]  nData;
    logic [15:0]        nCount;
    logic               packClear;
    logic               pixAccept;
    logic               wordAccept;
    logic [DATA_W-1:0]  packWord;
    logic               packLast;
    logic               packDone;

    gpu_fb_pixel_packer uPacker (
        .iClock       (iClock),
        .iReset       (iReset),
        .iClear       (packClear),
        .iShift       (pixAccept),
        .iPixel       (iPixel),
        .oWord_c      (packWord),
        .oLastPixel_c (packLast),
        .oWordDone_c  (packDone)
    );

    // Stall only the pixel that would complete a word while the previous one
    // is still waiting; a frame start in the same cycle also refuses the pixel.
    assign oPixelReady = (rState == FBW_ACTIVE) && !iFrameStart &&
                         !(oFrameBufferWe && !iFrameBufferReady && packLast);
    assign pixAccept   = iPixelValid && oPixelReady;
    assign wordAccept  = oFrameBufferWe && iFrameBufferReady;

    // State and output registers
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rState           <= FBW_IDLE;
            rWordAddr        <= '0;
            oFrameBufferWe   <= 1'b0;
            oFrameBufferAddr <= '0;
            oFrameBufferData <= '0;
            oFrameDone       <= 1'b0;
            oFrameAbort      <= 1'b0;
            oFrameCount      <= '0;
        end else begin
            rState           <= nState;
            rWordAddr        <= nWordAddr;
            oFrameBufferWe   <= nWe;
            oFrameBufferAddr <= nAddr;
            oFrameBufferData <= nData;
            oFrameDone       <= nDone;
            oFrameAbort      <= nAbort;
            oFrameCount      <= nCount;
        end
    end

    // Next-state, address and write-handshake logic
    always_comb begin
        nState    = rState;
        nWordAddr = rWordAddr;
        nWe       = oFrameBufferWe;
        nAddr     = oFrameBufferAddr;
        nData     = oFrameBufferData;
        nDone     = 1'b0;
        nAbort    = 1'b0;
        nCount    = oFrameCount;
        packClear = 1'b0;

        if (wordAccept) begin
            nWe = 1'b0;
        end

        case (rState)
            FBW_IDLE: begin
                if (iFrameStart) begin
                    nState    = FBW_ACTIVE;
                    nWordAddr = '0;
                    packClear = 1'b1;
                end
            end
            FBW_ACTIVE: begin
                if (iFrameStart) begin
                    nWe       = 1'b0;
                    nWordAddr = '0;
                    packClear = 1'b1;
                    nAbort    = 1'b1;
                end else if (packDone) begin
                    // Loading on the acceptance edge keeps We high for back-to-back words.
                    nWe   = 1'b1;
                    nAddr = rWordAddr;
                    nData = packWord;
                    if (rWordAddr == ADDR_W'(FB_WORDS - 1)) begin
                        nState = FBW_DRAIN;
                    end else begin
                        nWordAddr = rWordAddr + ADDR_W'(1);
                    end
                end
            end
            FBW_DRAIN: begin
                if (wordAccept) begin
                    // Completion takes precedence over a coincident start.
                    nDone  = 1'b1;
                    nCount = oFrameCount + 16'(1);
                    nState = FBW_IDLE;
                    if (iFrameStart) begin
                        nState    = FBW_ACTIVE;
                        nWordAddr = '0;
                        packClear = 1'b1;
                    end
                end else if (iFrameStart) begin
                    nWe       = 1'b0;
                    nWordAddr = '0;
                    packClear = 1'b1;
                    nAbort    = 1'b1;
                    nState    = FBW_ACTIVE;
                end
            end
            default: begin
                nState = FBW_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gpu_fb_writer.sv
// Directed bench for gpu_fb_writer: full frame, packing order, sink stall,
// mid-frame restart, start coincident with completion, and mid-write reset.
module tb_gpu_fb_writer;
    import gpu_fb_writer_pkg::*;

    logic                iClock;
    logic                iReset;
    logic                iFrameStart;
    logic                iPixelValid;
    logic [PIX_BITS-1:0] iPixel;
    logic                oPixelReady;
    logic                iFrameBufferReady;
    logic                oFrameBufferWe;
    logic [ADDR_W-1:0]   oFrameBufferAddr;
    logic [DATA_W-1:0]   oFrameBufferData;
    logic                oFrameDone;
    logic                oFrameAbort;
    logic [15:0]         oFrameCount;

    gpu_fb_writer dut (
        .iClock            (iClock),
        .iReset            (iReset),
        .iFrameStart       (iFrameStart),
        .iPixelValid       (iPixelValid),
        .iPixel            (iPixel),
        .oPixelReady       (oPixelReady),
        .iFrameBufferReady (iFrameBufferReady),
        .oFrameBufferWe    (oFrameBufferWe),
        .oFrameBufferAddr  (oFrameBufferAddr),
        .oFrameBufferData  (oFrameBufferData),
        .oFrameDone        (oFrameDone),
        .oFrameAbort       (oFrameAbort),
        .oFrameCount       (oFrameCount)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int passCnt     = 0;
    int checkCnt    = 0;
    int cyc         = 0;
    int wrCount     = 0;
    int lastWrAddr  = -1;
    int pixAcc      = 0;
    int doneCount   = 0;
    int abortCount  = 0;
    int orderErr    = 0;
    int gapErr      = 0;
    int expNextAddr = 0;
    int lastWrCyc   = -1;
    bit trackOrder  = 1'b0;
    bit trackGap    = 1'b0;
    bit lastPixAcc  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: note handshakes before the edge, then record registered outputs after it.
    task automatic cycle();
        logic        accW;
        logic [15:0] accA;
        #1;
        accW       = oFrameBufferWe && iFrameBufferReady;
        accA       = oFrameBufferAddr;
        lastPixAcc = iPixelValid && oPixelReady;
        @(posedge iClock);
        #1;
        cyc++;
        if (lastPixAcc) pixAcc++;
        if (accW) begin
            wrCount++;
            lastWrAddr = 32'(accA);
            if (trackOrder) begin
                if (32'(accA) != expNextAddr) orderErr++;
                expNextAddr = 32'(accA) + 1;
            end
            if (trackGap) begin
                if (lastWrCyc >= 0 && (cyc - lastWrCyc) != 8) gapErr++;
                lastWrCyc = cyc;
            end
        end
        if (oFrameDone)  doneCount++;
        if (oFrameAbort) abortCount++;
    endtask

    task automatic feed(input logic [1:0] pix);
        iPixelValid = 1'b1;
        iPixel      = pix;
        cycle();
    endtask

    initial begin
        logic [1:0] stallPix [8];
        int idx;
        int wrBefore;
        int abortBefore;
        int doneBefore;

        stallPix = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        iReset            = 1'b1;
        iFrameStart       = 1'b0;
        iPixelValid       = 1'b0;
        iPixel            = 2'd0;
        iFrameBufferReady = 1'b1;

        // Reset state
        cycle();
        cycle();
        iReset = 1'b0;
        #1;
        chk("rst_we",    32'(oFrameBufferWe),   32'd0);
        chk("rst_addr",  32'(oFrameBufferAddr), 32'd0);
        chk("rst_data",  32'(oFrameBufferData), 32'd0);
        chk("rst_done",  32'(oFrameDone),       32'd0);
        chk("rst_abort", 32'(oFrameAbort),      32'd0);
        chk("rst_count", 32'(oFrameCount),      32'd0);
        chk("rst_ready", 32'(oPixelReady),      32'd0);

        // Full frame at full rate; final word stalled, then start lands with its acceptance
        iFrameStart = 1'b1;
        cycle();
        iFrameStart = 1'b0;
        #1;
        chk("start_ready", 32'(oPixelReady), 32'd1);
        trackOrder  = 1'b1;
        trackGap    = 1'b1;
        expNextAddr = 0;
        lastWrCyc   = -1;
        for (int p = 0; p < 65536; p++) begin
            feed(2'(p % 4));
        end
        iPixelValid       = 1'b0;
        trackGap          = 1'b0;
        iFrameBufferReady = 1'b0;
        chk("last_we",   32'(oFrameBufferWe),   32'd1);
        chk("last_addr", 32'(oFrameBufferAddr), 32'd8191);
        chk("last_data", 32'(oFrameBufferData), 32'h1B1B);
        repeat (5) cycle();
        #1;
        chk("drain_ready", 32'(oPixelReady),      32'd0);
        chk("drain_addr",  32'(oFrameBufferAddr), 32'd8191);
        chk("drain_done",  32'(doneCount),        32'd0);
        iFrameBufferReady = 1'b1;
        iFrameStart       = 1'b1;
        cycle();
        iFrameStart = 1'b0;
        trackOrder  = 1'b0;
        chk("coin_done",   32'(oFrameDone),     32'd1);
        chk("coin_abort",  32'(oFrameAbort),    32'd0);
        chk("coin_count",  32'(oFrameCount),    32'd1);
        chk("coin_we",     32'(oFrameBufferWe), 32'd0);
        #1;
        chk("coin_ready",  32'(oPixelReady),    32'd1);
        chk("frame_writes", wrCount,     32'd8192);
        chk("frame_order",  orderErr,    32'd0);
        chk("frame_gap",    gapErr,      32'd0);
        chk("frame_pixels", pixAcc,      32'd65536);
        chk("frame_dones",  doneCount,   32'd1);
        chk("frame_aborts", abortCount,  32'd0);

        // Packing order into the restarted frame
        feed(2'd0);
        chk("done_pulse_end", 32'(oFrameDone), 32'd0);
        feed(2'd1); feed(2'd2); feed(2'd3);
        feed(2'd0); feed(2'd1); feed(2'd2); feed(2'd3);
        chk("pack_we",   32'(oFrameBufferWe),   32'd1);
        chk("pack_addr", 32'(oFrameBufferAddr), 32'd0);
        chk("pack_data", 32'(oFrameBufferData), 32'h1B1B);
        repeat (8) feed(2'd3);
        chk("ones_addr", 32'(oFrameBufferAddr), 32'd1);
        chk("ones_data", 32'(oFrameBufferData), 32'hFFFF);
        chk("ones_write0", lastWrAddr, 32'd0);

        // Sink stall of 20 cycles with word 1 pending
        iFrameBufferReady = 1'b0;
        idx = 0;
        begin
            int stallErr = 0;
            for (int c = 0; c < 20; c++) begin
                feed(stallPix[idx]);
                if (lastPixAcc) idx++;
                if (!oFrameBufferWe || oFrameBufferAddr != 16'd1 || oFrameBufferData != 16'hFFFF)
                    stallErr++;
            end
            chk("stall_stable", stallErr, 32'd0);
        end
        chk("stall_accepted", idx, 32'd7);
        #1;
        chk("stall_ready_low", 32'(oPixelReady), 32'd0);
        iFrameBufferReady = 1'b1;
        iPixel = stallPix[idx];
        #1;
        chk("stall_ready_high", 32'(oPixelReady), 32'd1);
        feed(stallPix[idx]);
        if (lastPixAcc) idx++;
        chk("stall_total",  idx, 32'd8);
        chk("stall_we",     32'(oFrameBufferWe),   32'd1);
        chk("stall_addr",   32'(oFrameBufferAddr), 32'd2);
        chk("stall_data",   32'(oFrameBufferData), 32'hE4E4);
        chk("stall_write1", lastWrAddr, 32'd1);

        // Restart with a pending word and a partial word
        iPixelValid = 1'b0;
        iFrameStart = 1'b1;
        cycle();
        iFrameStart = 1'b0;
        chk("abort1_pulse", 32'(oFrameAbort),    32'd1);
        chk("abort1_we",    32'(oFrameBufferWe), 32'd0);

        // 100 words plus 3 pixels, then restart with a pixel offered
        wrBefore = wrCount;
        repeat (803) feed(2'd2);
        chk("run_writes",    wrCount - wrBefore, 32'd100);
        chk("run_last_addr", lastWrAddr,         32'd99);
        iFrameStart = 1'b1;
        iPixelValid = 1'b1;
        iPixel      = 2'd3;
        #1;
        chk("abort2_ready", 32'(oPixelReady), 32'd0);
        cycle();
        iFrameStart = 1'b0;
        chk("abort2_pulse", 32'(oFrameAbort),    32'd1);
        chk("abort2_we",    32'(oFrameBufferWe), 32'd0);
        feed(2'd1);
        chk("abort2_pulse_end", 32'(oFrameAbort), 32'd0);
        repeat (7) feed(2'd1);
        chk("abort2_new_we",   32'(oFrameBufferWe),   32'd1);
        chk("abort2_new_addr", 32'(oFrameBufferAddr), 32'd0);
        chk("abort2_new_data", 32'(oFrameBufferData), 32'h5555);

        // Reset while a word is pending
        iPixelValid = 1'b0;
        abortBefore = abortCount;
        doneBefore  = doneCount;
        iReset = 1'b1;
        cycle();
        iReset = 1'b0;
        chk("mrst_we",    32'(oFrameBufferWe),   32'd0);
        chk("mrst_addr",  32'(oFrameBufferAddr), 32'd0);
        chk("mrst_data",  32'(oFrameBufferData), 32'd0);
        chk("mrst_count", 32'(oFrameCount),      32'd0);
        chk("mrst_pulses", (abortCount - abortBefore) + (doneCount - doneBefore), 32'd0);
        #1;
        chk("mrst_ready", 32'(oPixelReady), 32'd0);
        cycle();
        chk("mrst_quiet", 32'(oFrameAbort) + 32'(oFrameDone), 32'd0);
        iFrameStart = 1'b1;
        cycle();
        iFrameStart = 1'b0;
        repeat (8) feed(2'd2);
        chk("mrst_new_we",   32'(oFrameBufferWe),   32'd1);
        chk("mrst_new_addr", 32'(oFrameBufferAddr), 32'd0);
        chk("mrst_new_data", 32'(oFrameBufferData), 32'hAAAA);
        iPixelValid = 1'b0;

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
